dmem_store_buffer: RTL and testbench

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

---
 rtl/dmem_store_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Posted-write store buffer sitting between the core's data port and the
//   data memory. Writes are queued in a DEPTH-entry FIFO and acknowledged
//   after one cycle; a background FSM drains the FIFO to memory in order.
//   Reads wait for the FIFO to drain completely (no forwarding) and then go
//   to memory. Writes to MMIO_ADDR with byte lane 0 enabled also produce a
//   one-cycle console strobe when they are dequeued.
//
// Parameters
//   DEPTH     number of posted-write entries (power of two, >= 2)
//   MMIO_ADDR console address recognised on dequeue
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   cpu_valid/ready         core request handshake (ready is a 1-cycle pulse)
//   cpu_addr/wdata/wstrb    core request; wstrb != 0 means write
//   cpu_rdata               read data, valid while cpu_ready pulses
//   mem_valid/ready         memory request handshake
//   mem_addr/wdata/wstrb    memory request, held stable while mem_valid
//   mem_rdata               memory read data, sampled on mem_ready
//   con_valid, con_data     console byte strobe
//   stat_writes, stat_stall performance counters
//
// Build option
//   DMEM_SB_STATS_EN  when defined, stat_writes counts accepted writes and
//                     stat_stall counts cycles a pending request waits; when
//                     undefined both outputs are tied to zero.

module dmem_store_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MMIO_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic [31:0] cpu_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_stall
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    M_IDLE,
    M_WRITE,
    M_READ
  } mstate_t;

  // FIFO storage (plain RAM, not reset)
  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  strb_mem [DEPTH];

  mstate_t     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        con_valid_q, con_valid_d;
  logic [7:0]  con_data_q, con_data_d;

  logic req_live;
  logic is_write;
  logic enq;
  logic deq;
  logic rd_done;

  always_comb begin
    // a request is only looked at when we are not acknowledging the previous one
    req_live = cpu_valid && !cpu_ready_q;
    is_write = |cpu_wstrb;
    enq      = req_live && is_write && (count_q < DEPTH_C);
    deq      = (state_q == M_WRITE) && mem_ready;
    rd_done  = (state_q == M_READ) && mem_ready;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cpu_ready_d = enq || rd_done;
    cpu_rdata_d = cpu_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    con_valid_d = 1'b0;
    con_data_d  = con_data_q;

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      M_IDLE: begin
        // buffered writes always go first; a read only starts once empty
        if (count_q != '0) begin
          state_d     = M_WRITE;
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_mem[rd_ptr_q];
          mem_wdata_d = data_mem[rd_ptr_q];
          mem_wstrb_d = strb_mem[rd_ptr_q];
        end else if (req_live && !is_write) begin
          state_d     = M_READ;
          mem_valid_d = 1'b1;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
      end
      M_WRITE: begin
        if (mem_ready) begin
          state_d     = M_IDLE;
          mem_valid_d = 1'b0;
          rd_ptr_d    = rd_ptr_q + PW'(1);
          if ((mem_addr_q == MMIO_ADDR) && mem_wstrb_q[0]) begin
            con_valid_d = 1'b1;
            con_data_d  = mem_wdata_q[7:0];
          end
        end
      end
      M_READ: begin
        if (mem_ready) begin
          state_d     = M_IDLE;
          mem_valid_d = 1'b0;
          cpu_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d     = M_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= cpu_addr;
      data_mem[wr_ptr_q] <= cpu_wdata;
      strb_mem[wr_ptr_q] <= cpu_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= M_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign con_valid = con_valid_q;
  assign con_data  = con_data_q;

`ifdef DMEM_SB_STATS_EN
  logic [31:0] stat_writes_q, stat_writes_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        stall;

  always_comb begin
    // waiting: request visible, not taken this cycle, no ack outstanding
    stall         = req_live && !enq && !rd_done;
    stat_writes_d = stat_writes_q + 32'(enq);
    stat_stall_d  = stat_stall_q + 32'(stall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_writes_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_writes_q <= stat_writes_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_writes = stat_writes_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_writes = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Testbench for dmem_store_buffer (DEPTH=4): table of core operations with
// hand-computed results, plus directed sequences for stall, ordering,
// console, mid-operation reset and pointer wrap.

module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic [31:0] stat_writes;
  logic [31:0] stat_stall;

  dmem_store_buffer #(
    .DEPTH    (4),
    .MMIO_ADDR(32'h1000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_rdata  (cpu_rdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .con_valid  (con_valid),
    .con_data   (con_data),
    .stat_writes(stat_writes),
    .stat_stall (stat_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model and handshake log ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } hs_t;

  logic [31:0] mmodel [256];
  hs_t         wlog[$];
  int          hs_cyc[$];
  bit          mem_hold = 1'b0;
  int          con_cnt = 0;
  logic [7:0]  con_last = '0;

  always @(negedge clk) begin
    if (mem_valid && !mem_hold && !mem_ready) begin
      mem_ready = 1'b1;
      mem_rdata = mmodel[mem_addr[9:2]];
    end else begin
      mem_ready = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      wlog.delete();
      hs_cyc.delete();
      con_cnt = 0;
    end else begin
      if (mem_valid && mem_ready) begin
        wlog.push_back('{a: mem_addr, d: mem_wdata, s: mem_wstrb});
        hs_cyc.push_back(cyc + 1);
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mmodel[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
      if (con_valid) begin
        con_cnt++;
        con_last = con_data;
      end
    end
  end

  // ---------------- core-side driver ----------------
  task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat, output int rcyc);
    @(negedge clk);
    if (cpu_ready) @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wstrb = s;
    lat = 0;
    rd  = '0;
    rcyc = -1;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (cpu_ready) begin
        rd = cpu_rdata;
        rcyc = cyc;
        break;
      end
      if (lat > 300) begin
        checks++;
        errors++;
        $display("FAIL cpu_op_timeout: addr %h got no cpu_ready within %0d cycles", a, lat);
        break;
      end
    end
    cpu_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cpu_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int k = 0; k < 200 && wlog.size() < n; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] rd;
  int          lat;
  int          rcyc;
  int          n_acc;
  int          lats [10];
  int          rcycs [10];

  initial begin
    for (int i = 0; i < 256; i++) mmodel[i] = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    reset     = 1'b1;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_wstrb = '0;

    tbl[0] = '{1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h104, 32'h1122_3344, 4'hF, 32'h0};
    tbl[3] = '{1'b1, 32'h104, 32'hAABB_CCDD, 4'h3, 32'h0};
    tbl[4] = '{1'b0, 32'h104, 32'h0,         4'h0, 32'h1122_CCDD};
    tbl[5] = '{1'b1, 32'h108, 32'h5A00_0000, 4'h8, 32'h0};
    tbl[6] = '{1'b0, 32'h108, 32'h0,         4'h0, 32'h5A00_0000};
    tbl[7] = '{1'b0, 32'h10C, 32'h0,         4'h0, 32'h0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_con_valid", {31'b0, con_valid}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst_stat_writes", stat_writes, 32'h0);
    chk("rst_stat_stall", stat_stall, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // table: writes ack after one cycle, reads see drained data
    for (int i = 0; i < 8; i++) begin
      cpu_op(tbl[i].a, tbl[i].d, tbl[i].s, rd, lat, rcyc);
      if (tbl[i].wr) chk($sformatf("tbl%0d_wr_latency", i), lat, 1);
      else           chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
    end
    wait_log(8);
    chk("tbl_hs_count", wlog.size(), 8);
    if (wlog.size() > 0) begin
      chk("tbl_first_addr", wlog[0].a, 32'h100);
      chk("tbl_first_wdata", wlog[0].d, 32'hDEAD_BEEF);
      chk("tbl_first_wstrb", {28'b0, wlog[0].s}, 32'hF);
    end

    // 5 writes against a stalled memory: 4 fit, 5th waits for first dequeue
    do_reset();
    mem_hold = 1'b1;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          cpu_op(32'h200 + 32'(i) * 4, 32'hB000_0000 + 32'(i), 4'hF, rd, lats[i], rcycs[i]);
          n_acc++;
        end
      end
      begin
        repeat (20) @(posedge clk);
        #2;
        chk("full_accepted_before_release", n_acc, 4);
        chk("full_mem_valid_held", {31'b0, mem_valid}, 32'h1);
        mem_hold = 1'b0;
      end
    join
    for (int i = 0; i < 4; i++) chk($sformatf("full_lat%0d", i), lats[i], 1);
    wait_log(5);
    chk("full_hs_count", wlog.size(), 5);
    if (hs_cyc.size() > 0) chk("full_5th_accept_cycle", rcycs[4], hs_cyc[0] + 1);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      chk($sformatf("full_addr%0d", i), wlog[i].a, 32'h200 + 32'(i) * 4);
      chk($sformatf("full_data%0d", i), wlog[i].d, 32'hB000_0000 + 32'(i));
    end
`ifdef DMEM_SB_STATS_EN
    chk("stat_writes_5", stat_writes, 32'd5);
    chk("stat_stall_nonzero", {31'b0, stat_stall != 0}, 32'h1);
`else
    chk("stat_writes_off", stat_writes, 32'h0);
    chk("stat_stall_off", stat_stall, 32'h0);
`endif

    // read behind three buffered writes
    do_reset();
    mem_hold = 1'b1;
    cpu_op(32'h300, 32'hA1A1_0300, 4'hF, rd, lat, rcyc);
    cpu_op(32'h304, 32'hB2B2_0304, 4'hF, rd, lat, rcyc);
    cpu_op(32'h308, 32'hC3C3_0308, 4'hF, rd, lat, rcyc);
    fork
      cpu_op(32'h304, 32'h0, 4'h0, rd, lat, rcyc);
      begin
        repeat (10) @(posedge clk);
        #2;
        chk("rd_order_no_hs_while_held", wlog.size(), 0);
        mem_hold = 1'b0;
      end
    join
    chk("rd_order_rdata", rd, 32'hB2B2_0304);
    chk("rd_order_hs_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("rd_order_w0", wlog[0].a, 32'h300);
      chk("rd_order_w1", wlog[1].a, 32'h304);
      chk("rd_order_w2", wlog[2].a, 32'h308);
      chk("rd_order_read_addr", wlog[3].a, 32'h304);
      chk("rd_order_read_strb", {28'b0, wlog[3].s}, 32'h0);
    end

    // console strobe
    do_reset();
    cpu_op(32'h1000_0000, 32'h0000_0041, 4'h1, rd, lat, rcyc);
    wait_log(1);
    chk("con_count", con_cnt, 1);
    chk("con_data", {24'b0, con_last}, 32'h41);
    chk("con_mem_issued", wlog.size(), 1);
    cpu_op(32'h1000_0000, 32'h0000_4200, 4'h2, rd, lat, rcyc);
    cpu_op(32'h0000_0110, 32'h0000_0055, 4'h1, rd, lat, rcyc);
    wait_log(3);
    chk("con_no_extra_pulse", con_cnt, 1);

    // reset with entries pending and a request on the bus
    do_reset();
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) cpu_op(32'h500 + 32'(i) * 4, 32'hE000_0000 + 32'(i), 4'hF, rd, lat, rcyc);
    for (int k = 0; k < 20 && !mem_valid; k++) @(posedge clk);
    #1;
    chk("midrst_mem_valid_before", {31'b0, mem_valid}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_mem_valid_after", {31'b0, mem_valid}, 32'h0);
    chk("midrst_mem_addr_after", mem_addr, 32'h0);
    chk("midrst_cpu_ready_after", {31'b0, cpu_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mem_hold = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_requests", wlog.size(), 0);
    chk("midrst_mem_valid_idle", {31'b0, mem_valid}, 32'h0);
    cpu_op(32'h304, 32'h0, 4'h0, rd, lat, rcyc);
    chk("midrst_read_rdata", rd, 32'hB2B2_0304);
    chk("midrst_read_only_hs", wlog.size(), 1);

    // pointer wrap: 10 writes, memory stalled early on
    do_reset();
    mem_hold = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++)
          cpu_op(32'h400 + 32'(i) * 4, 32'h0000_1000 + 32'(i), 4'hF, rd, lats[i], rcycs[i]);
      end
      begin
        repeat (12) @(posedge clk);
        mem_hold = 1'b0;
      end
    join
    wait_log(10);
    chk("wrap_hs_count", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      chk($sformatf("wrap_addr%0d", i), wlog[i].a, 32'h400 + 32'(i) * 4);
      chk($sformatf("wrap_data%0d", i), wlog[i].d, 32'h0000_1000 + 32'(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
